// File: rtl/kbd_ascii_ctrl.sv
// PS/2 make-code decoder feeding an external scan-to-ASCII lookup, with a
// first-word-fall-through character FIFO and a sticky overflow flag.
module kbd_ascii_ctrl #(
  parameter int ADDR_W         = 2,
  parameter int FILTER_UNKNOWN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_done_tick,
  output logic [7:0] key_code,
  input  logic [7:0] ascii_code,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, WRITE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      key_code_q, key_code_d;
  logic [7:0]      last_key_q, last_key_d;
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
  logic            ovf_q;
  logic [7:0]      mem_q [DEPTH];

  logic push_req, push, pop, ovf_set;

  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    last_key_d = last_key_q;
    case (state_q)
      IDLE: if (scan_done_tick) begin
        if (scan_code == 8'hF0)            state_d = BRK;
        else if (scan_code == 8'hE0)       state_d = EXT;
        else if (scan_code != last_key_q) begin
          key_code_d = scan_code;
          last_key_d = scan_code;
          state_d    = WRITE;
        end
      end
      BRK: if (scan_done_tick) begin
        if (scan_code == last_key_q) last_key_d = 8'h00;
        state_d = IDLE;
      end
      EXT: if (scan_done_tick) begin
        state_d = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
      end
      EXT_BRK: if (scan_done_tick) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Unknown-key lookups are dropped silently: no push and no overflow.
  assign push_req = (state_q == WRITE) && !((FILTER_UNKNOWN != 0) && (ascii_code == 8'h2A));
  assign push     = push_req && (!full || rd_en);
  assign pop      = rd_en && !empty;
  assign ovf_set  = (push_req && full && !rd_en) || ((state_q == WRITE) && scan_done_tick);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      key_code_q <= 8'h00;
      last_key_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      last_key_q <= last_key_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      // A set event wins over a same-cycle clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= ascii_code;
  end

  assign key_code = key_code_q;
  assign overflow = ovf_q;
  assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_kbd_ascii_ctrl.sv
// Directed bench for kbd_ascii_ctrl with a behavioural scan-to-ASCII lookup.
module tb_kbd_ascii_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_done_tick = 1'b0;
  logic [7:0] key_code;
  logic [7:0] ascii_code;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overflow;
  logic       clr_ovf = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  kbd_ascii_ctrl #(.ADDR_W(2), .FILTER_UNKNOWN(1)) dut (
    .clk(clk), .reset_n(reset_n), .scan_code(scan_code),
    .scan_done_tick(scan_done_tick), .key_code(key_code),
    .ascii_code(ascii_code), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lookup(input logic [7:0] k);
    case (k)
      8'h1C: lookup = 8'h41;
      8'h16: lookup = 8'h31;
      8'h1E: lookup = 8'h32;
      8'h26: lookup = 8'h33;
      8'h25: lookup = 8'h34;
      8'h2E: lookup = 8'h35;
      default: lookup = 8'h2A;
    endcase
  endfunction

  assign ascii_code = lookup(key_code);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  // Tick, then one idle cycle so the WRITE state (if any) completes.
  task automatic send(input logic [7:0] code);
    @(negedge clk); scan_code = code; scan_done_tick = 1'b1;
    @(negedge clk); scan_done_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_empty", {7'd0, empty}, 8'd1);
    chk("rst_full", {7'd0, full}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_key_code", key_code, 8'h00);
    #22 reset_n = 1'b1;

    // Single key, latency and pop
    @(negedge clk); scan_code = 8'h1C; scan_done_tick = 1'b1;
    @(negedge clk); scan_done_tick = 1'b0;
    chk("lat_empty_n1", {7'd0, empty}, 8'd1);
    chk("lat_key_code", key_code, 8'h1C);
    @(negedge clk);
    chk("lat_empty_n2", {7'd0, empty}, 8'd0);
    chk("lat_rd_data", rd_data, 8'h41);
    pop();
    chk("pop_empty", {7'd0, empty}, 8'd1);
    pop();
    chk("pop_on_empty", {7'd0, empty}, 8'd1);

    // Typematic suppression and break clearing last_key
    send(8'hF0); send(8'h1C);
    chk("brk_no_write", {7'd0, empty}, 8'd1);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("rep_empty", {7'd0, empty}, 8'd0);
    chk("rep_ovf", {7'd0, overflow}, 8'd0);
    chk("rep_e0", rd_data, 8'h41);
    pop();
    chk("rep_e1", rd_data, 8'h41);
    chk("rep_e1_valid", {7'd0, empty}, 8'd0);
    pop();
    chk("rep_drained", {7'd0, empty}, 8'd1);

    // Extended sequences are discarded and leave last_key (1C) alone
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_empty", {7'd0, empty}, 8'd1);
    send(8'h1C);
    chk("ext_lastkey_kept", {7'd0, empty}, 8'd1);
    send(8'hF0); send(8'h1C);

    // Fill, overflow, ordered drain, clear
    send(8'h16); send(8'h1E); send(8'h26);
    chk("fill3_full", {7'd0, full}, 8'd0);
    send(8'h25);
    chk("fill4_full", {7'd0, full}, 8'd1);
    chk("fill4_ovf", {7'd0, overflow}, 8'd0);
    send(8'h2E);
    chk("fill5_ovf", {7'd0, overflow}, 8'd1);
    chk("fill5_full", {7'd0, full}, 8'd1);
    chk("drain0", rd_data, 8'h31); pop();
    chk("drain1", rd_data, 8'h32); pop();
    chk("drain2", rd_data, 8'h33); pop();
    chk("drain3", rd_data, 8'h34); pop();
    chk("drain_empty", {7'd0, empty}, 8'd1);
    chk("ovf_sticky", {7'd0, overflow}, 8'd1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_cleared", {7'd0, overflow}, 8'd0);

    // Full FIFO with a pop in the WRITE cycle: both succeed
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    chk("refill_full", {7'd0, full}, 8'd1);
    @(negedge clk); scan_code = 8'h2E; scan_done_tick = 1'b1;
    @(negedge clk); scan_done_tick = 1'b0; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    chk("pp_ovf", {7'd0, overflow}, 8'd0);
    chk("pp_full", {7'd0, full}, 8'd1);
    chk("pp_d0", rd_data, 8'h32); pop();
    chk("pp_d1", rd_data, 8'h33); pop();
    chk("pp_d2", rd_data, 8'h34); pop();
    chk("pp_d3", rd_data, 8'h35); pop();
    chk("pp_empty", {7'd0, empty}, 8'd1);

    // Unknown key filtered
    send(8'h0D);
    chk("unk_empty", {7'd0, empty}, 8'd1);
    chk("unk_ovf", {7'd0, overflow}, 8'd0);

    // Tick during WRITE with simultaneous clr_ovf: set wins
    @(negedge clk); scan_code = 8'h1C; scan_done_tick = 1'b1;
    @(negedge clk); scan_code = 8'h33; clr_ovf = 1'b1;
    @(negedge clk); scan_done_tick = 1'b0; clr_ovf = 1'b0;
    chk("wr_tick_ovf", {7'd0, overflow}, 8'd1);
    chk("wr_tick_data", rd_data, 8'h41);

    // Reset while in BRK aborts and flushes
    send(8'hF0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_empty", {7'd0, empty}, 8'd1);
    chk("mid_rst_ovf", {7'd0, overflow}, 8'd0);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    send(8'h1C);
    chk("post_rst_empty", {7'd0, empty}, 8'd0);
    chk("post_rst_data", rd_data, 8'h41);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
